// File: rtl/duv_mem_arb_pkg.sv
// Shared types and default sizes for the duv memory arbiter.
package duv_mem_arb_pkg;

  localparam int NUM_REQ     = 4;
  localparam int MEM_ADDR_W  = 10;
  localparam int MEM_DATA_W  = 32;
  localparam int BURST_LEN_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/duv_mem_arb_rr.sv
// Round-robin picker: nearest active requester after the last winner, wrapping.
module duv_mem_arb_rr
  import duv_mem_arb_pkg::*;
#(
  parameter int REQUESTERS = NUM_REQ,
  parameter int IDX_W      = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req,
  input  logic [IDX_W-1:0]      last,
  output logic [REQUESTERS-1:0] win_oh,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  win_vld
);

  logic [IDX_W-1:0] cand;

  // Scan farthest offset first so the nearest active requester is the one left standing.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = REQUESTERS; k >= 1; k--) begin
      cand = IDX_W'((int'(last) + k) % REQUESTERS);
      if (req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    win_oh = win_vld ? (REQUESTERS'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/duv_mem_arb.sv
// Round-robin burst arbiter in front of the single-port duv memory.
// One beat per cycle while the winner holds req; a dropped req aborts the burst.
module duv_mem_arb
  import duv_mem_arb_pkg::*;
#(
  parameter int REQUESTERS = NUM_REQ,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int LEN_W      = BURST_LEN_W
) (
  input  logic                         duv_mem_arb_clk_ip,
  input  logic                         duv_mem_arb_rst_ip,
  input  logic [REQUESTERS-1:0]        duv_mem_arb_req_ip,
  input  logic [REQUESTERS-1:0]        duv_mem_arb_we_ip,
  input  logic [REQUESTERS*ADDR_W-1:0] duv_mem_arb_addr_ip,
  input  logic [REQUESTERS*LEN_W-1:0]  duv_mem_arb_len_ip,
  input  logic [REQUESTERS*DATA_W-1:0] duv_mem_arb_wdata_ip,
  output logic [REQUESTERS-1:0]        duv_mem_arb_gnt_op,
  output logic [REQUESTERS-1:0]        duv_mem_arb_ack_op,
  output logic [REQUESTERS-1:0]        duv_mem_arb_rvalid_op,
  output logic [DATA_W-1:0]            duv_mem_arb_rdata_op,
  output logic                         duv_mem_arb_busy_op,
  output logic                         duv_mem_arb_mem_en_op,
  output logic                         duv_mem_arb_mem_we_op,
  output logic [ADDR_W-1:0]            duv_mem_arb_mem_addr_op,
  output logic [DATA_W-1:0]            duv_mem_arb_mem_wdata_op,
  input  logic [DATA_W-1:0]            duv_mem_arb_mem_rdata_ip
);

  localparam int IDX_W = $clog2(REQUESTERS);

  arb_state_t              state_p0;
  logic [IDX_W-1:0]        last_p0;   // current winner in BURST, last winner in IDLE
  logic [REQUESTERS-1:0]   gnt_p0;
  logic                    we_p0;
  logic [ADDR_W-1:0]       addr_p0;
  logic [LEN_W-1:0]        cnt_p0;
  logic [REQUESTERS-1:0]   vld_p1;

  logic [REQUESTERS-1:0]   pick_oh;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_vld;
  logic                    req_win;
  logic                    beat;

  duv_mem_arb_rr #(
    .REQUESTERS (REQUESTERS),
    .IDX_W      (IDX_W)
  ) u_rr (
    .req     (duv_mem_arb_req_ip),
    .last    (last_p0),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

  // A beat is issued only while the granted requester still holds its request.
  always_comb begin
    req_win = duv_mem_arb_req_ip[last_p0];
    beat    = (state_p0 == BURST) && req_win;
  end

  // Burst FSM: grant in IDLE, leave BURST on the last beat or on an abort.
  always_ff @(posedge duv_mem_arb_clk_ip or posedge duv_mem_arb_rst_ip) begin
    if (duv_mem_arb_rst_ip) begin
      state_p0 <= IDLE;
      last_p0  <= IDX_W'(REQUESTERS - 1);
      gnt_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (pick_vld) begin
            state_p0 <= BURST;
            last_p0  <= pick_idx;
            gnt_p0   <= pick_oh;
          end
        end
        BURST: begin
          if (!req_win || (cnt_p0 == '0)) begin
            state_p0 <= IDLE;
            gnt_p0   <= '0;
          end
        end
        default: begin
          state_p0 <= IDLE;
          gnt_p0   <= '0;
        end
      endcase
    end
  end

  // Burst parameters captured at grant, then address/beat count stepped per issued beat.
  always_ff @(posedge duv_mem_arb_clk_ip) begin
    if ((state_p0 == IDLE) && pick_vld) begin
      we_p0   <= duv_mem_arb_we_ip[pick_idx];
      addr_p0 <= duv_mem_arb_addr_ip[int'(pick_idx)*ADDR_W +: ADDR_W];
      cnt_p0  <= duv_mem_arb_len_ip[int'(pick_idx)*LEN_W +: LEN_W];
    end else if (beat) begin
      addr_p0 <= addr_p0 + ADDR_W'(1);
      cnt_p0  <= cnt_p0 - LEN_W'(1);
    end
  end

  // Read-beat marker aligned with the memory's one-cycle read latency.
  always_ff @(posedge duv_mem_arb_clk_ip or posedge duv_mem_arb_rst_ip) begin
    if (duv_mem_arb_rst_ip) begin
      vld_p1 <= '0;
    end else begin
      vld_p1 <= (beat && !we_p0) ? gnt_p0 : '0;
    end
  end

  // Output drive: memory side and strobes are zero whenever no beat is issued.
  always_comb begin
    duv_mem_arb_gnt_op       = gnt_p0;
    duv_mem_arb_busy_op      = (state_p0 == BURST);
    duv_mem_arb_ack_op       = beat ? gnt_p0 : '0;
    duv_mem_arb_mem_en_op    = beat;
    duv_mem_arb_mem_we_op    = beat && we_p0;
    duv_mem_arb_mem_addr_op  = beat ? addr_p0 : '0;
    duv_mem_arb_mem_wdata_op = beat ? duv_mem_arb_wdata_ip[int'(last_p0)*DATA_W +: DATA_W] : '0;
    duv_mem_arb_rvalid_op    = vld_p1;
    duv_mem_arb_rdata_op     = (|vld_p1) ? duv_mem_arb_mem_rdata_ip : '0;
  end

endmodule

// File: tb/tb_duv_mem_arb.sv
// Bench for duv_mem_arb: directed table and sequences, then random bursts vs a transaction model.
module tb_duv_mem_arb;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  we;
  logic [N*AW-1:0] addr;
  logic [N*LW-1:0] len;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  gnt, ack, rvalid;
  logic [DW-1:0] rdata;
  logic          busy, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rd = '0;

  logic [DW-1:0] tmem [0:1023];
  bit   [1023:0] wr_seen;
  logic [DW-1:0] sh   [0:1023];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] mask;
    int           exp;
  } rr_vec_t;

  typedef struct {
    int          idx;
    bit          w;
    int          a;
    logic [31:0] d;
    int          cy;
  } beat_t;

  always #5 clk = ~clk;

  duv_mem_arb dut (
    .duv_mem_arb_clk_ip       (clk),
    .duv_mem_arb_rst_ip       (rst),
    .duv_mem_arb_req_ip       (req),
    .duv_mem_arb_we_ip        (we),
    .duv_mem_arb_addr_ip      (addr),
    .duv_mem_arb_len_ip       (len),
    .duv_mem_arb_wdata_ip     (wdata),
    .duv_mem_arb_gnt_op       (gnt),
    .duv_mem_arb_ack_op       (ack),
    .duv_mem_arb_rvalid_op    (rvalid),
    .duv_mem_arb_rdata_op     (rdata),
    .duv_mem_arb_busy_op      (busy),
    .duv_mem_arb_mem_en_op    (mem_en),
    .duv_mem_arb_mem_we_op    (mem_we),
    .duv_mem_arb_mem_addr_op  (mem_addr),
    .duv_mem_arb_mem_wdata_op (mem_wdata),
    .duv_mem_arb_mem_rdata_ip (mem_rd)
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  // Memory array: preloaded pattern until a location is written, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        tmem[mem_addr]    <= mem_wdata;
        wr_seen[mem_addr] <= 1'b1;
      end else begin
        mem_rd <= wr_seen[mem_addr] ? tmem[mem_addr] : init_word(int'(mem_addr));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    req = '0; we = '0; addr = '0; len = '0; wdata = '0;
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input int a, input int l,
                         input logic [31:0] d);
    req[i] = r;
    we[i]  = w;
    addr[i*AW +: AW] = AW'(a);
    len[i*LW +: LW]  = LW'(l);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    clear_in();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " strobes"}, 32'({gnt, ack, rvalid, busy, mem_en, mem_we}), 32'h0);
    chk({nm, " mem_addr"}, 32'(mem_addr), 32'h0);
    chk({nm, " mem_wdata"}, mem_wdata, 32'h0);
    chk({nm, " rdata"}, rdata, 32'h0);
  endtask

  // Lone-requester burst, checked beat by beat including the trailing read valid.
  task automatic run_burst(input int i, input bit w, input int a, input int l,
                           input logic [31:0] dv [4], input string tag);
    logic [N-1:0] oh;
    oh = N'(1) << i;
    cyc();
    set_req(i, 1'b1, w, a, l, dv[0]);
    #1;
    chk({tag, " idle gnt"}, 32'(gnt), 32'h0);
    for (int c = 1; c <= l + 1; c++) begin
      cyc();
      set_req(i, 1'b1, w, a, l, dv[c-1]);
      #1;
      chk({tag, " ack"}, 32'(ack), 32'(oh));
      chk({tag, " gnt"}, 32'(gnt), 32'(oh));
      chk({tag, " addr"}, 32'(mem_addr), 32'((a + c - 1) % 1024));
      chk({tag, " mem_we"}, 32'(mem_we), 32'(w));
      if (w) begin
        chk({tag, " wdata"}, mem_wdata, dv[c-1]);
      end else if (c >= 2) begin
        chk({tag, " rvalid"}, 32'(rvalid), 32'(oh));
        chk({tag, " rdata"}, rdata, dv[c-2]);
      end
    end
    cyc();
    req[i] = 1'b0;
    #1;
    chk({tag, " busy end"}, 32'(busy), 32'h0);
    if (!w) begin
      chk({tag, " last rvalid"}, 32'(rvalid), 32'(oh));
      chk({tag, " last rdata"}, rdata, dv[l]);
    end
    cyc();
    #1;
    chk({tag, " rvalid quiet"}, 32'(rvalid), 32'h0);
  endtask

  initial begin
    rr_vec_t     tbl [12];
    logic [31:0] dv [4];
    logic [31:0] wv [4];
    int          nb;
    beat_t       eq [$];
    beat_t       e;
    logic [31:0] dat [N][4];
    int          rl [N];
    int          ra [N];
    bit          rw [N];
    int          bd [N];
    bit          act [N];
    bit          pend [N];
    int          npend;
    int          last_m;
    int          t;
    int          w;
    int          a;
    logic [31:0] d;
    logic [N-1:0] mask;
    logic [N-1:0] exp_rv;
    logic [31:0]  exp_rd;

    tbl = '{
      '{4'b1111, 0}, '{4'b1001, 3}, '{4'b1001, 0}, '{4'b0101, 2},
      '{4'b0011, 0}, '{4'b0001, 0}, '{4'b1110, 1}, '{4'b0010, 1},
      '{4'b1100, 2}, '{4'b0100, 2}, '{4'b1011, 3}, '{4'b0110, 1}
    };
    for (int i = 0; i < 1024; i++) sh[i] = init_word(i);

    rst = 1'b1;
    clear_in();
    cyc();
    chk_all_zero("reset");
    cyc();
    rst = 1'b0;
    cyc();
    #1;
    chk("post reset busy", 32'(busy), 32'h0);

    // Round-robin table: single len-0 read bursts, winner follows the previous grant.
    for (int k = 0; k < 12; k++) begin
      cyc();
      clear_in();
      for (int i = 0; i < N; i++) if (tbl[k].mask[i]) set_req(i, 1'b1, 1'b0, i * 64 + k, 0, 32'h0);
      #1;
      chk("tbl idle gnt", 32'(gnt), 32'h0);
      cyc();
      #1;
      chk("tbl gnt", 32'(gnt), 32'(N'(1) << tbl[k].exp));
      chk("tbl mem_addr", 32'(mem_addr), 32'(tbl[k].exp * 64 + k));
      cyc();
      clear_in();
      #1;
      chk("tbl busy", 32'(busy), 32'h0);
    end

    // Single read burst from preloaded memory.
    for (int b = 0; b < 4; b++) dv[b] = init_word(16 + b);
    run_burst(0, 1'b0, 16, 3, dv, "rd0");

    // Write burst wrapping 0x3FF -> 0x000, then read it back.
    wv = '{32'hDEAD_0001, 32'hBEEF_0002, 32'hCAFE_0003, 32'hF00D_0004};
    run_burst(1, 1'b1, 1022, 3, wv, "wr1");
    for (int b = 0; b < 4; b++) sh[(1022 + b) % 1024] = wv[b];
    run_burst(1, 1'b0, 1022, 3, wv, "rb1");

    // All four held, len 0: grants 0,1,2,3,0 with an idle cycle between each.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (c == 0) for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 256 + i, 0, 32'h0);
      #1;
      chk("held gnt", 32'(gnt), (c % 2 == 1) ? 32'(N'(1) << (((c - 1) / 2) % N)) : 32'h0);
      chk("held busy", 32'(busy), 32'(c % 2));
    end
    cyc();
    clear_in();

    // Abort: requester 2 drops after its second ack, requester 3 follows.
    do_reset();
    nb = 0;
    cyc();
    set_req(2, 1'b1, 1'b0, 64, 3, 32'h0);
    set_req(3, 1'b1, 1'b0, 128, 3, 32'h0);
    #1;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      if (c == 3) req[2] = 1'b0;
      #1;
      if (ack[2]) nb++;
      if (c == 3) begin
        chk("abort mem_en", 32'(mem_en), 32'h0);
        chk("abort ack", 32'(ack), 32'h0);
      end
      if (c == 4) begin
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort rvalid", 32'(rvalid), 32'h0);
      end
      if (c == 5) chk("abort next gnt", 32'(gnt), 32'b1000);
    end
    chk("abort beats", 32'(nb), 32'd2);
    cyc();
    clear_in();

    // Reset in the middle of a read burst.
    do_reset();
    cyc();
    set_req(0, 1'b1, 1'b0, 32, 3, 32'h0);
    #1;
    cyc();
    #1;
    chk("mid ack", 32'(ack), 32'b0001);
    cyc();
    rst = 1'b1;
    #1;
    chk_all_zero("mid reset");
    cyc();
    clear_in();
    #1;
    chk("mid rvalid held", 32'(rvalid), 32'h0);
    cyc();
    rst = 1'b0;
    #1;
    chk("mid rvalid rel", 32'(rvalid), 32'h0);
    chk("mid mem_en rel", 32'(mem_en), 32'h0);
    cyc();
    set_req(1, 1'b1, 1'b0, 4, 0, 32'h0);
    set_req(3, 1'b1, 1'b0, 8, 0, 32'h0);
    #1;
    cyc();
    #1;
    chk("post reset gnt", 32'(gnt), 32'b0010);
    cyc();
    clear_in();

    // Random rounds against a transaction-level model.
    do_reset();
    last_m = N - 1;
    exp_rv = '0;
    exp_rd = '0;
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        rw[i] = 1'($urandom_range(0, 1));
        ra[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1020, 1023))
                                            : int'($urandom_range(0, 1023));
        rl[i] = int'($urandom_range(0, 3));
        for (int b = 0; b < 4; b++) dat[i][b] = $urandom;
        bd[i]   = 0;
        act[i]  = mask[i];
        pend[i] = mask[i];
      end
      npend = 0;
      for (int i = 0; i < N; i++) if (pend[i]) npend++;
      t = 0;
      while (npend > 0) begin
        w = -1;
        for (int k = 1; k <= N; k++) if (w < 0 && pend[(last_m + k) % N]) w = (last_m + k) % N;
        for (int b = 0; b <= rl[w]; b++) begin
          a = (ra[w] + b) % 1024;
          if (rw[w]) begin
            sh[a] = dat[w][b];
            d = dat[w][b];
          end else begin
            d = sh[a];
          end
          eq.push_back('{w, rw[w], a, d, t + 1 + b});
        end
        t += rl[w] + 2;
        last_m = w;
        pend[w] = 1'b0;
        npend--;
      end
      for (int rel = 0; rel < t; rel++) begin
        cyc();
        clear_in();
        for (int i = 0; i < N; i++) if (act[i]) set_req(i, 1'b1, rw[i], ra[i], rl[i], dat[i][bd[i]]);
        #1;
        chk("rnd rvalid", 32'(rvalid), 32'(exp_rv));
        if (exp_rv != '0) chk("rnd rdata", rdata, exp_rd);
        exp_rv = '0;
        if (ack != '0) begin
          if (eq.size() == 0) begin
            chk("rnd extra ack", 32'(ack), 32'h0);
          end else begin
            e = eq.pop_front();
            chk("rnd ack", 32'(ack), 32'(N'(1) << e.idx));
            chk("rnd beat cycle", 32'(rel), 32'(e.cy));
            chk("rnd addr", 32'(mem_addr), 32'(e.a));
            chk("rnd mem_we", 32'(mem_we), 32'(e.w));
            if (e.w) begin
              chk("rnd wdata", mem_wdata, e.d);
            end else begin
              exp_rv = N'(1) << e.idx;
              exp_rd = e.d;
            end
            bd[e.idx]++;
            if (bd[e.idx] > rl[e.idx]) act[e.idx] = 1'b0;
          end
        end else if (eq.size() != 0 && eq[0].cy == rel) begin
          chk("rnd missing beat", 32'(ack), 32'(N'(1) << eq[0].idx));
        end
      end
      chk("rnd leftover beats", 32'(eq.size()), 32'h0);
      eq.delete();
      for (int i = 0; i < N; i++) act[i] = 1'b0;
    end
    cyc();
    clear_in();
    #1;
    chk("rnd final rvalid", 32'(rvalid), 32'(exp_rv));
    if (exp_rv != '0) chk("rnd final rdata", rdata, exp_rd);
    cyc();
    #1;
    chk("rnd quiet busy", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/duv_mem_arb.md
# duv_mem_arb

Round-robin arbiter that shares the single-port 1024 x 32 duv memory between several requesters. It issues fixed-length read/write bursts with auto-incrementing, wrapping addresses and returns read data with a per-requester valid strobe. It sits inside duv, between the requester ports and the memory array.

## Interface
- REQUESTERS, 4, number of requesters (2..8)
- ADDR_W, 10, memory address width (1024 words)
- DATA_W, 32, memory data width
- LEN_W, 2, burst length field; beats = len+1 (1..4)

- duv_mem_arb_clk_ip  in  1  clock, all logic on rising edge
- duv_mem_arb_rst_ip  in  1  reset, asynchronous, active-high
- duv_mem_arb_req_ip  in  REQUESTERS  burst request, one bit per requester
- duv_mem_arb_we_ip  in  REQUESTERS  1 = write burst, 0 = read burst
- duv_mem_arb_addr_ip  in  REQUESTERS*ADDR_W  burst start address (flattened, requester i at [i*ADDR_W +: ADDR_W])
- duv_mem_arb_len_ip  in  REQUESTERS*LEN_W  burst length minus one
- duv_mem_arb_wdata_ip  in  REQUESTERS*DATA_W  write data for current beat
- duv_mem_arb_gnt_op  out  REQUESTERS  one-hot grant, high for the whole burst
- duv_mem_arb_ack_op  out  REQUESTERS  one-hot beat accept strobe
- duv_mem_arb_rvalid_op  out  REQUESTERS  one-hot read data valid
- duv_mem_arb_rdata_op  out  DATA_W  read data, broadcast
- duv_mem_arb_busy_op  out  1  burst in progress
- duv_mem_arb_mem_en_op  out  1  memory access enable
- duv_mem_arb_mem_we_op  out  1  memory write enable
- duv_mem_arb_mem_addr_op  out  ADDR_W  memory address
- duv_mem_arb_mem_wdata_op  out  DATA_W  memory write data
- duv_mem_arb_mem_rdata_ip  in  DATA_W  memory read data, 1-cycle latency after mem_en

## Operation
- States: IDLE, BURST.
- IDLE: if any req bit set, pick winner by round-robin; capture winner index, we, addr, len; go to BURST. No req: stay IDLE.
- Round-robin: search starts at last granted + 1, wrapping. Reset value of last granted = REQUESTERS-1, so requester 0 wins first.
- BURST: one beat per cycle. Beat: mem_en=1, mem_we=captured we, mem_addr=current address, mem_wdata=wdata slice of granted requester (sampled per beat); ack[winner]=1.
- Address increments by 1 per beat, wraps 1023 -> 0 (modulo 2^ADDR_W).
- Beat counter counts down from len; the beat with counter 0 is the last; next state IDLE.
- Requester must hold req high until its last ack. If req[winner] drops mid-burst: no beat issued that cycle (mem_en=0, ack=0), burst aborted, return to IDLE.
- addr/len/we changes during a burst are ignored; wdata must change only after ack.
- Read beats: rvalid[winner] asserted the cycle after the beat; rdata_op = mem_rdata_ip combinationally.
- gnt_op = one-hot winner while in BURST, else 0. busy_op = (state == BURST).

## Timing
- Reset (asynchronous): state IDLE, all outputs 0, last granted = REQUESTERS-1, pending rvalid cleared; a burst in flight is discarded, no further beats or rvalid.
- req seen in IDLE at cycle N -> gnt, first beat and ack at N+1; last beat at N+1+len; IDLE at N+2+len.
- One turnaround IDLE cycle between bursts; back-to-back peak throughput = (len+1)/(len+2).
- Read latency: request to first rvalid = 2 cycles.
- Simultaneous requests: exactly one grant; others wait, req held.
- Abort on final beat cycle behaves as abort (final beat not issued).
- rvalid of final read beat coincides with the turnaround IDLE cycle and must be produced.

## Structure
- Package duv_mem_arb_pkg: state enum (IDLE, BURST), default width constants (ADDR_W, DATA_W, LEN_W).
- Sub-module duv_mem_arb_rr: combinational round-robin picker (req vector, last index -> one-hot winner + index, valid).
- Top holds FSM, capture registers, address/beat counters, rvalid pipeline register.

## Test plan
- Single read, req[0], addr 0x010, len 3 -> ack[0] at cycles 1..4, mem_addr 0x010..0x013, rvalid[0] cycles 2..5 with preloaded data.
- Write burst addr 0x3FE, len 3 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001; readback matches written words.
- req = 4'b1111 held, len 0 each -> grants in order 0,1,2,3,0, one IDLE cycle between each.
- req[2] dropped after 2nd ack of len 3 burst -> exactly 2 beats issued, busy_op low next cycle, next requester granted after.
- Reset asserted mid read burst (after beat 1) -> all outputs 0 immediately, no rvalid afterwards; after release req[1]+req[3] -> requester 1 granted first.
